fifo_rr_arbiter: RTL and testbench

//  Downstream consumer of the four input-class FIFOs.
//  - Pops them round-robin and routes each word to one of four output FIFOs.
//  - Destination = word bits [DATA_SIZE-1:DATA_SIZE-2].
//  - Sits between the input FIFO bank and the output FIFO bank.
//  - Obeys the output FIFOs' pause (almost-full) flags.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_rr_arbiter_rr_pick.sv | 27 ++
 rtl/fifo_rr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and state type for the input-FIFO round-robin arbiter.
package fifo_arb_pkg;

  localparam int NUM_Q         = 4;
  localparam int ID_W          = 2;
  localparam int DEF_DATA_SIZE = 6;
  localparam int DEST_MSB      = DEF_DATA_SIZE - 1;
  localparam int DEST_LSB      = DEF_DATA_SIZE - 2;
  localparam int CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin search: first non-empty queue after the pointer, wrapping once.
module rr_pick
  import fifo_arb_pkg::*;
(
  input  logic [ID_W-1:0]  i_ptr,
  input  logic [NUM_Q-1:0] i_empty,
  output logic [ID_W-1:0]  o_g,
  output logic             o_valid
);

  logic [ID_W-1:0] w_idx;

  // k = NUM_Q wraps back to the pointer itself, so it is searched last
  always_comb begin
    o_g     = i_ptr;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_Q; k++) begin
      w_idx = i_ptr + ID_W'(k);
      if (!o_valid && !i_empty[w_idx]) begin
        o_valid = 1'b1;
        o_g     = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of four input FIFOs into four output FIFOs chosen by word MSBs.
// Optional per-output push counters enabled by defining FIFO_ARB_CNT_EN.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int NUM_Q     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_Q-1:0]           fifo_empty_in,
  input  logic [NUM_Q*DATA_SIZE-1:0] fifo_data_in,
  output logic [NUM_Q-1:0]           fifo_pop,
  input  logic [NUM_Q-1:0]           out_pause,
  output logic [NUM_Q-1:0]           out_push,
  output logic [DATA_SIZE-1:0]       data_out,
  output logic [1:0]                 grant_id,
  output logic                       arb_idle
`ifdef FIFO_ARB_CNT_EN
  ,
  output logic [NUM_Q*fifo_arb_pkg::CNT_W-1:0] push_count
`endif
);

  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_s1_id;
  logic                 r_s1_vld;
  logic                 r_s2_vld;
  logic [DATA_SIZE-1:0] r_word;
  logic [DATA_SIZE-1:0] w_in_word;
  logic [ID_W-1:0]      w_g;
  logic [ID_W-1:0]      w_dest;
  logic                 w_g_vld;
  logic                 w_any_ne;
  logic                 w_any_pause;
  logic                 w_pop_en;

  assign w_any_ne    = ~&fifo_empty_in;
  assign w_any_pause = |out_pause;
  assign w_in_word   = fifo_data_in[r_s1_id*DATA_SIZE +: DATA_SIZE];
  assign w_dest      = r_word[DATA_SIZE-1 -: ID_W];

  rr_pick u_pick (
    .i_ptr   (r_ptr),
    .i_empty (fifo_empty_in),
    .o_g     (w_g),
    .o_valid (w_g_vld)
  );

  // Pause gates the pop combinationally so popping stops in the cycle it rises
  always_comb begin
    w_next   = r_state;
    w_pop_en = 1'b0;
    fifo_pop = '0;
    grant_id = '0;
    unique case (r_state)
      IDLE: if (w_any_ne && !w_any_pause) w_next = RUN;
      RUN: begin
        if (w_any_pause)   w_next = HOLD;
        else if (!w_any_ne) w_next = IDLE;
        w_pop_en = w_g_vld && !w_any_pause;
      end
      HOLD: if (!w_any_pause) w_next = w_any_ne ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
    if (w_pop_en) begin
      fifo_pop[w_g] = 1'b1;
      grant_id      = w_g;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '1;
      r_s1_vld <= 1'b0;
      r_s1_id  <= '0;
      r_s2_vld <= 1'b0;
      r_word   <= '0;
    end else begin
      r_state  <= w_next;
      if (w_pop_en) r_ptr <= w_g;
      r_s1_vld <= w_pop_en;
      r_s1_id  <= w_g;
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_word <= w_in_word;
    end
  end

  always_comb begin
    out_push = '0;
    if (r_s2_vld) out_push[w_dest] = 1'b1;
    data_out = r_word;
    arb_idle = (r_state == IDLE) && !r_s1_vld && !r_s2_vld;
  end

`ifdef FIFO_ARB_CNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_Q];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_Q; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_Q; i++)
        if (out_push[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    push_count = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) push_count[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter with a behavioural input-FIFO model.
module tb_fifo_rr_arbiter;

  typedef struct {
    logic [5:0]  word;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_empty_in;
  logic [23:0] fifo_data_in;
  logic [3:0]  fifo_pop;
  logic [3:0]  out_pause;
  logic [3:0]  out_push;
  logic [5:0]  data_out;
  logic [1:0]  grant_id;
  logic        arb_idle;
`ifdef FIFO_ARB_CNT_EN
  logic [31:0] push_count;
`endif

  logic [5:0]  mq[4][$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_push   = 0;
  int unsigned cyc      = 0;
  logic [3:0]  last_pop;
  logic [3:0]  last_push;
  logic [1:0]  last_gid;

  fifo_rr_arbiter #(.DATA_SIZE(6), .NUM_Q(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty_in (fifo_empty_in),
    .fifo_data_in  (fifo_data_in),
    .fifo_pop      (fifo_pop),
    .out_pause     (out_pause),
    .out_push      (out_push),
    .data_out      (data_out),
    .grant_id      (grant_id),
    .arb_idle      (arb_idle)
`ifdef FIFO_ARB_CNT_EN
    ,
    .push_count    (push_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: sample/check at negedge, then apply pops to the FIFO model after posedge
  task automatic cycle();
    logic [3:0] pop;
    int         g;
    exp_t       e;
    @(negedge clk);
    pop       = fifo_pop;
    last_pop  = pop;
    last_push = out_push;
    last_gid  = grant_id;
    g         = -1;
    if (!reset) begin
      n_checks++;
      if ($countones(pop) > 1) begin
        n_fail++;
        $display("FAIL pop_onehot: got %b expected at most one bit", pop);
      end
      for (int i = 0; i < 4; i++) if (pop[i]) g = i;
      if (g >= 0) begin
        n_checks++;
        if (mq[g].size() == 0) begin
          n_fail++;
          $display("FAIL pop_empty: popped q%0d with depth 0, expected no pop", g);
        end else begin
          e.word = mq[g][0];
          e.cyc  = cyc + 2;
          exp_q.push_back(e);
        end
        n_checks++;
        if (grant_id !== 2'(g)) begin
          n_fail++;
          $display("FAIL grant_id: got %0d expected %0d", grant_id, g);
        end
      end
      if (out_push != 4'b0) begin
        n_push++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_push: got push=%b data=%b expected no push", out_push, data_out);
        end else begin
          e = exp_q.pop_front();
          if (out_push !== (4'b0001 << e.word[5:4]) || data_out !== e.word || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL push: got push=%b data=%b cyc=%0d expected push=%b data=%b cyc=%0d",
                     out_push, data_out, cyc, 4'b0001 << e.word[5:4], e.word, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_checks++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL missing_push: got no push at cyc %0d expected data=%b", cyc, e.word);
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      exp_q.delete();
      fifo_empty_in = '1;
      fifo_data_in  = '0;
    end else if (g >= 0 && mq[g].size() > 0) begin
      fifo_data_in[g*6 +: 6] = mq[g].pop_front();
      fifo_empty_in[g]       = (mq[g].size() == 0);
    end
    cyc++;
  endtask

  task automatic load(input int q, input logic [5:0] w);
    mq[q].push_back(w);
    fifo_empty_in[q] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_pop != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_empty_in != 4'hF) && k < 400) begin
      cycle();
      k++;
    end
    repeat (3) cycle();
    n_checks++;
    if (exp_q.size() != 0 || fifo_empty_in !== 4'hF) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending pushes, empty=%b expected 0 pending, empty=1111",
               name, exp_q.size(), fifo_empty_in);
    end
    n_checks++;
    if (arb_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle: got arb_idle=%b expected 1", name, arb_idle);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (fifo_pop !== 4'b0) begin n_fail++; $display("FAIL reset_pop: got %b expected 0000", fifo_pop); end
    n_checks++;
    if (out_push !== 4'b0) begin n_fail++; $display("FAIL reset_push: got %b expected 0000", out_push); end
    n_checks++;
    if (data_out !== 6'b0) begin n_fail++; $display("FAIL reset_data: got %b expected 000000", data_out); end
    n_checks++;
    if (arb_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", arb_idle); end
    n_checks++;
    if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    repeat (3) cycle();
    n_checks++;
    if (last_pop !== 4'b0 || arb_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_stays_idle: got pop=%b idle=%b expected pop=0000 idle=1", last_pop, arb_idle);
    end
  endtask

  task automatic test_rr_order();
    logic [3:0] exp_pop [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bit ok;
    do_reset();
    load(0, 6'b11_0101);
    load(1, 6'b00_1010);
    load(2, 6'b01_1111);
    load(3, 6'b10_0000);
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_first_pop: got no pop in 10 cycles expected a pop"); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle();
      n_checks++;
      if (last_pop !== exp_pop[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %b expected %b", k, last_pop, exp_pop[k]);
      end
    end
    cycle();
    n_checks++;
    if (last_pop !== 4'b0) begin n_fail++; $display("FAIL rr_after: got %b expected 0000", last_pop); end
    drain("rr");
  endtask

  task automatic test_single_queue();
    bit ok;
    do_reset();
    load(2, 6'b10_0001);
    load(2, 6'b01_0010);
    load(2, 6'b11_0011);
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_first_pop: got no pop in 10 cycles expected a pop"); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cycle();
      n_checks++;
      if (last_pop !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_pop[%0d]: got %b expected 0100", k, last_pop);
      end
    end
    cycle();
    n_checks++;
    if (last_pop !== 4'b0) begin n_fail++; $display("FAIL single_after: got %b expected 0000", last_pop); end
    drain("single");
  endtask

  task automatic test_pause();
    bit ok;
    int p0;
    do_reset();
    for (int k = 0; k < 8; k++) load(0, {2'b01, 4'(k)});
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pause_first_pop: got no pop in 10 cycles expected a pop"); end
    cycle();
    cycle();
    out_pause = 4'b0010;
    p0 = n_push;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++;
      if (last_pop !== 4'b0) begin
        n_fail++;
        $display("FAIL pause_pop[%0d]: got %b expected 0000", k, last_pop);
      end
    end
    n_checks++;
    if (n_push - p0 != 2) begin
      n_fail++;
      $display("FAIL pause_inflight: got %0d pushes expected 2", n_push - p0);
    end
    out_pause = 4'b0;
    cycle();
    n_checks++;
    if (last_pop !== 4'b0) begin n_fail++; $display("FAIL pause_clear_cycle: got %b expected 0000", last_pop); end
    cycle();
    n_checks++;
    if (last_pop !== 4'b0001) begin n_fail++; $display("FAIL pause_resume: got %b expected 0001", last_pop); end
    drain("pause");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    load(1, 6'b10_0001);
    load(1, 6'b10_0010);
    load(1, 6'b10_0011);
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrst_first_pop: got no pop in 10 cycles expected a pop"); end
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (arb_idle !== 1'b1 || out_push !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst_state: got idle=%b push=%b expected idle=1 push=0000", arb_idle, out_push);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (last_push !== 4'b0) begin
        n_fail++;
        $display("FAIL midrst_no_push[%0d]: got %b expected 0000", k, last_push);
      end
    end
    load(3, 6'b00_0001);
    load(0, 6'b00_0010);
    wait_pop(ok);
    n_checks++;
    if (last_pop !== 4'b0001 || last_gid !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_ptr: got pop=%b grant=%0d expected pop=0001 grant=0", last_pop, last_gid);
    end
    drain("midrst");
  endtask

`ifdef FIFO_ARB_CNT_EN
  task automatic test_count();
    do_reset();
    n_checks++;
    if (push_count !== 32'h0) begin n_fail++; $display("FAIL count_reset: got %h expected 00000000", push_count); end
    for (int k = 0; k < 300; k++) load(0, {2'b00, 4'(k)});
    drain("count");
    n_checks++;
    if (push_count[7:0] !== 8'd255) begin
      n_fail++;
      $display("FAIL count_sat: got %0d expected 255", push_count[7:0]);
    end
    n_checks++;
    if (push_count[31:8] !== 24'h0) begin
      n_fail++;
      $display("FAIL count_others: got %h expected 000000", push_count[31:8]);
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    fifo_empty_in = '1;
    fifo_data_in  = '0;
    out_pause     = '0;
    test_reset();
    test_rr_order();
    test_single_queue();
    test_pause();
    test_reset_mid();
`ifdef FIFO_ARB_CNT_EN
    test_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
